// File: rtl/lsu_data_mem.sv
// Load/store data memory for the RV64I datapath.
// Supports b/h/w/d accesses with sign or zero extension. An access that crosses a word
// boundary is either split over two cycles or faulted, as chosen by SPLIT_MISALIGNED.
module lsu_data_mem #(
  parameter int unsigned XLEN             = 64,
  parameter int unsigned DEPTH            = 1024,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [63:0]     req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_fault,
  output logic            busy
);

  localparam int unsigned B    = XLEN / 8;
  localparam int unsigned OFF  = $clog2(B);
  localparam int unsigned IDXW = $clog2(DEPTH);
  localparam int unsigned TOPB = OFF + IDXW;

  typedef enum logic [0:0] {StIdle, StSecond} state_e;

  state_e state_q, state_d;

  // Storage; never reset or initialised.
  logic [XLEN-1:0] mem [DEPTH];

  // Request decode
  logic            accept;
  logic [IDXW-1:0] idx;
  logic [OFF-1:0]  lane;
  logic [3:0]      size_bytes;
  logic            illegal;
  logic            out_of_range;
  logic            misaligned;
  logic            crosses;
  logic            last_word;
  logic            fault;
  logic [B-1:0]    be_base;
  logic [2*B-1:0]  wide_be;
  logic [2*XLEN-1:0] wide_wdata;

  // Captured request and read data
  logic            resp_valid_q;
  logic            fault_q;
  logic            write_q;
  logic [2:0]      f3_q;
  logic [OFF-1:0]  lane_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] idx_hi;
  logic [XLEN-1:0] wdata_hi_q;
  logic [B-1:0]    be_hi_q;
  logic [XLEN-1:0] rd_lo_q;
  logic [XLEN-1:0] rd_hi_q;

  // Response formatting
  logic [XLEN-1:0]        aligned;
  logic [6:0]             shamt;
  logic [XLEN-1:0]        shifted;
  logic [XLEN-1:0]        zext;
  logic signed [XLEN-1:0] sext;

  // Decode the request: index, lane, size, fault conditions and lane-shifted write data.
  always_comb begin
    idx          = req_addr[TOPB-1:OFF];
    lane         = req_addr[OFF-1:0];
    size_bytes   = 4'd1 << req_funct3[1:0];
    illegal      = (req_funct3 == 3'b111) || (req_write && req_funct3[2]) ||
                   ((XLEN == 32) && ((req_funct3 == 3'b011) || (req_funct3 == 3'b110)));
    out_of_range = |req_addr[63:TOPB];
    misaligned   = (req_addr[2:0] & 3'(size_bytes - 4'd1)) != 3'd0;
    crosses      = (5'(lane) + 5'(size_bytes)) > 5'(B);
    last_word    = (idx == IDXW'(DEPTH - 1));
    fault        = illegal || out_of_range || (!SPLIT_MISALIGNED && misaligned) ||
                   (crosses && last_word);
    be_base = '0;
    for (int b = 0; b < B; b++) begin
      be_base[b] = (4'(b) < size_bytes);
    end
    // Two-word window: low half goes to idx, high half to idx+1 on a split.
    wide_be    = {{B{1'b0}}, be_base} << lane;
    wide_wdata = {{XLEN{1'b0}}, req_wdata} << {lane, 3'b000};
    accept     = req_valid && req_ready && !rst;
    idx_hi     = idx_q + IDXW'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      StIdle: begin
        req_ready = 1'b1;
        if (accept && !fault && crosses) begin
          state_d = StSecond;
        end
      end
      StSecond: begin
        busy    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Capture request attributes and produce the one-cycle response pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid_q <= 1'b0;
      fault_q      <= 1'b0;
      write_q      <= 1'b0;
      f3_q         <= 3'd0;
      lane_q       <= '0;
      idx_q        <= '0;
      wdata_hi_q   <= '0;
      be_hi_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      if (accept) begin
        write_q      <= req_write;
        f3_q         <= req_funct3;
        lane_q       <= lane;
        idx_q        <= idx;
        fault_q      <= fault;
        wdata_hi_q   <= wide_wdata[2*XLEN-1:XLEN];
        be_hi_q      <= wide_be[2*B-1:B];
        // A split request responds after its second access instead.
        resp_valid_q <= fault || !crosses;
      end else if (state_q == StSecond) begin
        resp_valid_q <= 1'b1;
      end
    end
  end

  // Array port: first access on acceptance, second access in StSecond.
  always_ff @(posedge clk) begin
    if (accept && !fault) begin
      if (req_write) begin
        for (int b = 0; b < B; b++) begin
          if (wide_be[b]) begin
            mem[idx][8*b +: 8] <= wide_wdata[8*b +: 8];
          end
        end
      end else begin
        rd_lo_q <= mem[idx];
      end
    end
    if (state_q == StSecond) begin
      if (write_q) begin
        for (int b = 0; b < B; b++) begin
          if (be_hi_q[b]) begin
            mem[idx_hi][8*b +: 8] <= wdata_hi_q[8*b +: 8];
          end
        end
      end else begin
        rd_hi_q <= mem[idx_hi];
      end
    end
  end

  // Align the read window to the addressed lane and extend from bit 8S-1.
  always_comb begin
    aligned = XLEN'({rd_hi_q, rd_lo_q} >> {lane_q, 3'b000});
    unique case (f3_q[1:0])
      2'b00:   shamt = 7'(XLEN - 8);
      2'b01:   shamt = 7'(XLEN - 16);
      2'b10:   shamt = 7'(XLEN - 32);
      default: shamt = 7'd0;
    endcase
    shifted    = aligned << shamt;
    zext       = shifted >> shamt;
    sext       = $signed(shifted) >>> shamt;
    resp_valid = resp_valid_q;
    resp_fault = resp_valid_q && fault_q;
    resp_rdata = '0;
    if (resp_valid_q && !fault_q && !write_q) begin
      resp_rdata = f3_q[2] ? zext : XLEN'(sext);
    end
  end

endmodule

// File: tb/tb_lsu_data_mem.sv
// Directed bench for lsu_data_mem: table of single requests plus hand-written
// sequences for split timing, reset mid-split and back-to-back traffic.
module tb_lsu_data_mem;

  localparam logic [2:0] FB = 3'd0, FH = 3'd1, FW = 3'd2, FD = 3'd3;
  localparam logic [2:0] FBU = 3'd4, FHU = 3'd5, FWU = 3'd6, FBAD = 3'd7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid_a = 1'b0, valid_b = 1'b0;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        ready_a, rvalid_a, fault_a, busy_a;
  logic        ready_b, rvalid_b, fault_b, busy_b;
  logic [63:0] rdata_a, rdata_b;

  always #5 clk = ~clk;

  lsu_data_mem #(.XLEN(64), .DEPTH(1024), .SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_ready(ready_a), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rvalid_a), .resp_rdata(rdata_a), .resp_fault(fault_a), .busy(busy_a)
  );

  lsu_data_mem #(.XLEN(64), .DEPTH(1024), .SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_ready(ready_b), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(rvalid_b), .resp_rdata(rdata_b), .resp_fault(fault_b), .busy(busy_b)
  );

  typedef struct {
    bit          sel;
    bit          w;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wd;
    bit          flt;
    logic [63:0] rd;
    int          lat;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic st(input bit sel, input logic [2:0] f3, input logic [63:0] a,
                    input logic [63:0] wd, input bit flt, input int lat);
    vecs.push_back('{sel, 1'b1, f3, a, wd, flt, 64'd0, lat});
  endtask

  task automatic ld(input bit sel, input logic [2:0] f3, input logic [63:0] a,
                    input bit flt, input logic [63:0] rd, input int lat);
    vecs.push_back('{sel, 1'b0, f3, a, 64'd0, flt, rd, lat});
  endtask

  // Issue one request, then watch four cycles for its response.
  task automatic run_req(input bit sel, input bit w, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd,
                         output int lat, output logic [63:0] rd, output logic flt,
                         output int pulses);
    @(negedge clk);
    req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    @(posedge clk);
    #1 valid_a = 1'b0; valid_b = 1'b0;
    lat = 0; rd = '0; flt = 1'b0; pulses = 0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (sel ? rvalid_b : rvalid_a) begin
        pulses++;
        if (lat == 0) begin
          lat = c;
          rd  = sel ? rdata_b : rdata_a;
          flt = sel ? fault_b : fault_a;
        end
      end
    end
  endtask

  initial begin
    int          lat, pulses;
    logic [63:0] rd;
    logic        flt;

    // Sign/zero extension
    st(0, FD,  64'h10, 64'h1122334455667788, 0, 1);
    ld(0, FB,  64'h10, 0, 64'hFFFFFFFFFFFFFF88, 1);
    ld(0, FBU, 64'h10, 0, 64'h88, 1);
    ld(0, FH,  64'h16, 0, 64'h1122, 1);
    ld(0, FW,  64'h14, 0, 64'h11223344, 1);
    ld(0, FHU, 64'h10, 0, 64'h7788, 1);
    ld(0, FWU, 64'h10, 0, 64'h55667788, 1);
    ld(0, FD,  64'h10, 0, 64'h1122334455667788, 1);
    st(0, FD,  64'h30, 64'h0, 0, 1);
    st(0, FW,  64'h30, 64'hFFFFFFFF8000F00D, 0, 1);
    ld(0, FW,  64'h30, 0, 64'hFFFFFFFF8000F00D, 1);
    ld(0, FWU, 64'h30, 0, 64'h8000F00D, 1);
    ld(0, FH,  64'h30, 0, 64'hFFFFFFFFFFFFF00D, 1);
    ld(0, FHU, 64'h32, 0, 64'h8000, 1);
    ld(0, FD,  64'h30, 0, 64'h000000008000F00D, 1);
    // Misaligned within one word
    ld(0, FH,  64'h11, 0, 64'h6677, 1);
    ld(0, FW,  64'h12, 0, 64'h33445566, 1);
    // Byte-lane store
    st(0, FD,  64'h20, 64'h0, 0, 1);
    st(0, FB,  64'h23, 64'hFFFFFFFFFFFFFFAB, 0, 1);
    ld(0, FD,  64'h20, 0, 64'h00000000AB000000, 1);
    // Split accesses
    st(0, FD,  64'h18, 64'h0, 0, 1);
    st(0, FW,  64'h1E, 64'h00000000AABBCCDD, 0, 2);
    ld(0, FW,  64'h1E, 0, 64'hFFFFFFFFAABBCCDD, 2);
    ld(0, FD,  64'h18, 0, 64'hCCDD000000000000, 1);
    ld(0, FD,  64'h20, 0, 64'h00000000AB00AABB, 1);
    ld(0, FHU, 64'h1F, 0, 64'hBBCC, 2);
    st(0, FD,  64'h28, 64'h0, 0, 1);
    st(0, FH,  64'h27, 64'h1234, 0, 2);
    ld(0, FD,  64'h20, 0, 64'h34000000AB00AABB, 1);
    ld(0, FD,  64'h28, 0, 64'h12, 1);
    // Faults
    ld(0, FD,  64'h2000, 1, 64'h0, 1);
    st(0, FD,  64'h1FF8, 64'h0123456789ABCDEF, 0, 1);
    st(0, FD,  64'h1FFC, 64'hFFFFFFFFFFFFFFFF, 1, 1);
    ld(0, FW,  64'h1FFE, 1, 64'h0, 1);
    ld(0, FD,  64'h1FF8, 0, 64'h0123456789ABCDEF, 1);
    ld(0, FBAD, 64'h10, 1, 64'h0, 1);
    st(0, FBAD, 64'h10, 64'h0, 1, 1);
    st(0, FBU, 64'h10, 64'h0, 1, 1);
    st(0, FD,  64'h2010, 64'h0, 1, 1);
    ld(0, FD,  64'h10, 0, 64'h1122334455667788, 1);
    // SPLIT_MISALIGNED=0 instance
    st(1, FD,  64'h10, 64'h1122334455667788, 0, 1);
    ld(1, FH,  64'h11, 1, 64'h0, 1);
    st(1, FH,  64'h11, 64'hFFFF, 1, 1);
    st(1, FW,  64'h16, 64'hFFFFFFFF, 1, 1);
    ld(1, FD,  64'h10, 0, 64'h1122334455667788, 1);
    ld(1, FH,  64'h12, 0, 64'h5566, 1);

    // Reset state
    #1 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset resp_valid", 64'(rvalid_a), 64'd0);
    check("reset busy", 64'(busy_a), 64'd0);
    rst = 1'b0;
    #1;
    check("reset req_ready", 64'(ready_a), 64'd1);
    check("reset resp_rdata", rdata_a, 64'd0);
    check("reset resp_fault", 64'(fault_a), 64'd0);

    foreach (vecs[i]) begin
      run_req(vecs[i].sel, vecs[i].w, vecs[i].f3, vecs[i].addr, vecs[i].wd,
              lat, rd, flt, pulses);
      check($sformatf("v%0d latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d rdata", i), rd, vecs[i].rd);
      check($sformatf("v%0d fault", i), 64'(flt), 64'(vecs[i].flt));
      check($sformatf("v%0d pulses", i), 64'(pulses), 64'd1);
    end

    // Split timing: ready low / busy high at T+1, response at T+2.
    @(negedge clk);
    req_write = 1'b0; req_funct3 = FW; req_addr = 64'h1E; valid_a = 1'b1;
    @(posedge clk);
    #1 valid_a = 1'b0;
    @(negedge clk);
    check("split T+1 req_ready", 64'(ready_a), 64'd0);
    check("split T+1 busy", 64'(busy_a), 64'd1);
    check("split T+1 resp_valid", 64'(rvalid_a), 64'd0);
    @(negedge clk);
    check("split T+2 resp_valid", 64'(rvalid_a), 64'd1);
    check("split T+2 rdata", rdata_a, 64'hFFFFFFFFAABBCCDD);
    check("split T+2 req_ready", 64'(ready_a), 64'd1);
    check("split T+2 busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    check("split T+3 resp_valid", 64'(rvalid_a), 64'd0);

    // Reset during the second half of a split store.
    run_req(0, 1, FD, 64'h18, 64'h0, lat, rd, flt, pulses);
    run_req(0, 1, FD, 64'h20, 64'h0123456789ABCDEF, lat, rd, flt, pulses);
    @(negedge clk);
    req_write = 1'b1; req_funct3 = FW; req_addr = 64'h1E; req_wdata = 64'hAABBCCDD;
    valid_a = 1'b1;
    @(posedge clk);
    #1 valid_a = 1'b0;
    #1;
    check("midsplit busy before rst", 64'(busy_a), 64'd1);
    rst = 1'b1;
    #1;
    check("midsplit rst busy", 64'(busy_a), 64'd0);
    check("midsplit rst resp_valid", 64'(rvalid_a), 64'd0);
    check("midsplit rst req_ready", 64'(ready_a), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (rvalid_a) pulses++;
    end
    check("midsplit no response", 64'(pulses), 64'd0);
    run_req(0, 0, FD, 64'h18, 64'h0, lat, rd, flt, pulses);
    check("midsplit word 0x18", rd, 64'hCCDD000000000000);
    run_req(0, 0, FD, 64'h20, 64'h0, lat, rd, flt, pulses);
    check("midsplit word 0x20", rd, 64'h0123456789ABCDEF);

    // Back-to-back store then load to the same word.
    @(negedge clk);
    req_write = 1'b1; req_funct3 = FD; req_addr = 64'h40; req_wdata = 64'hDEADBEEFCAFEF00D;
    valid_a = 1'b1;
    @(posedge clk);
    #1 req_write = 1'b0;
    @(negedge clk);
    check("b2b store resp_valid", 64'(rvalid_a), 64'd1);
    check("b2b store rdata", rdata_a, 64'd0);
    check("b2b req_ready", 64'(ready_a), 64'd1);
    @(posedge clk);
    #1 valid_a = 1'b0;
    @(negedge clk);
    check("b2b load resp_valid", 64'(rvalid_a), 64'd1);
    check("b2b load rdata", rdata_a, 64'hDEADBEEFCAFEF00D);
    check("b2b load fault", 64'(fault_a), 64'd0);
    @(negedge clk);
    check("b2b idle resp_valid", 64'(rvalid_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_data_mem.md
# lsu_data_mem

Parametrised load/store data memory for the RV64I datapath, replacing the doubleword-only data memory. It takes one load or store request per handshake and supports byte, half, word and doubleword accesses selected by RISC-V funct3, with sign or zero extension on loads. Misaligned accesses that cross a word boundary are either split into two array accesses or faulted, selected by a parameter. It sits between the ALU address output and the write-back mux.

## Interface

Parameters:
- XLEN, 64: data width in bits; legal values are 32 or 64. One array word is XLEN bits.
- DEPTH, 1024: number of array words; must be a power of two, at least 2.
- SPLIT_MISALIGNED, 1: 1 = accesses crossing a word boundary are split into two accesses; 0 = any misaligned access faults.

Ports:
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_funct3  in  3  access size and sign; RISC-V load/store funct3 encoding.
- req_addr  in  64  byte address.
- req_wdata  in  XLEN  store data; the low-order bytes are used.
- resp_valid  out  1  one-cycle pulse; the response is present.
- resp_rdata  out  XLEN  extended load data; 0 for stores and faults.
- resp_fault  out  1  request rejected; no array write occurred for this request.
- busy  out  1  high while a split second access is pending.

## Operation

- Let B = XLEN/8 and OFF = log2(B). The word index is addr[OFF+log2(DEPTH)-1:OFF]. The byte lane is addr[OFF-1:0]. Byte order is little-endian.
- funct3 encoding:
  - 000 = b, signed.
  - 001 = h, signed.
  - 010 = w, signed.
  - 011 = d.
  - 100 = bu.
  - 101 = hu.
  - 110 = wu.
  - 111 = illegal.
- For XLEN=32, funct3 011 and 110 are illegal.
- For stores, only funct3 000 to 011 are legal.
- Size S = 2^funct3[1:0] bytes. An access is misaligned when addr mod S ≠ 0. It crosses a word when lane + S > B.
- A request faults if any of the following holds; all are checked at acceptance, before any write:
  - funct3 is illegal.
  - Any address bit at or above OFF+log2(DEPTH) is set.
  - SPLIT_MISALIGNED=0 and the access is misaligned.
  - The access crosses a word and the index is DEPTH−1 (no second word exists).
- Stores write only the addressed byte lanes, using per-byte enables. There is no read-modify-write cycle.
- Loads are zero- or sign-extended from bit 8S−1 to XLEN bits.
- FSM has two states:
  - IDLE: req_ready=1. Accepting a crossing, non-faulting request moves to SECOND. Any other accepted request stays in IDLE.
  - SECOND: req_ready=0, busy=1. Accesses word index+1 with the remaining lanes, then returns to IDLE.
- A misaligned access that does not cross a word (SPLIT_MISALIGNED=1) completes in a single access.
- Memory contents are not reset or initialised.

## Timing

- Reset values: state=IDLE, req_ready=1 (after reset deasserts), resp_valid=0, resp_rdata=0, resp_fault=0, busy=0.
- Acceptance occurs at the rising edge where req_valid & req_ready are both high. Call that edge T.
- Single-access request: the array is written or read at T. resp_valid is high during cycle T+1 only.
- Throughput is one request per cycle. Back-to-back requests are accepted while resp_valid is high.
- Faulting request: no write at T. resp_valid=1, resp_fault=1, resp_rdata=0 during T+1.
- Crossing request:
  - The first word is accessed at T and the second word at T+1.
  - req_ready=0 and busy=1 during cycle T+1.
  - resp_valid is high during T+2.
  - The lower-address bytes come from the first word.
- Read-after-write: a load accepted the edge after a store to the same word returns the new data. No forwarding is needed; reads occur at later edges.
- resp_valid has no backpressure. The consumer must take the response in its valid cycle.
- Reset mid-split: the FSM returns to IDLE immediately and no response is produced. The first half of a split store stays written and the second half is not written.
- Inputs are ignored while req_ready=0.

## Test plan

- Sign and zero extension (XLEN=64): sd 0x1122334455667788 at address 0x10. Then:
  - lb 0x10 → 0xFFFFFFFFFFFFFF88.
  - lbu 0x10 → 0x88.
  - lh 0x16 → 0x1122.
  - lw 0x14 → 0x11223344.
  - Each response arrives one cycle after acceptance.
- Byte-lane store: sd 0 at 0x20, then sb 0xAB at 0x23, then ld 0x20 → 0x00000000AB000000.
- Split access (SPLIT_MISALIGNED=1): sw 0xAABBCCDD at 0x1E, then lw 0x1E.
  - Load returns 0xFFFFFFFFAABBCCDD.
  - req_ready and busy: low 0, high 1 during T+1.
  - resp_valid at T+2.
  - ld 0x18 shows 0xCCDD in bits 63:48. ld 0x20 shows 0xAABB in bits 15:0.
- Faults, each returning resp_fault=1 and resp_rdata=0 at T+1, with a following ld confirming memory is unchanged:
  - SPLIT_MISALIGNED=0: lh 0x11.
  - Out-of-range address 0x2000 with DEPTH=1024.
  - sd crossing at 0x1FFC.
  - funct3=111.
- Reset mid-split: assert rst during SECOND of sw 0xAABBCCDD at 0x1E.
  - Outputs clear asynchronously and no resp_valid is produced.
  - Afterwards ld 0x18 shows 0xCCDD in bits 63:48, and word 0x20 is unchanged.
- Back-to-back: a store at 0x40 followed by a load at 0x40 on consecutive cycles. The load returns the new data, and two resp_valid pulses occur on consecutive cycles.
